// File: rtl/demux_1x4_stream_pkg.sv
// Shared types for the 1:4 stream demux: channel indices, slot states, stats width.
// Latency: n/a. Backpressure: n/a.
package demux_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 16;

  typedef enum logic [SEL_W-1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_D = 2'd3
  } ch_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [CH_NUM-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [CH_NUM-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_1x4_stream_if.sv
// Stream bundle for the 1:4 demux: one upstream port and four downstream channels.
// Latency: n/a. Backpressure: valid/ready on the input and on every channel.
interface demux_1x4_stream_if #(
  parameter int DATA_W = 8
) ();

  logic [1:0]        sel_in;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [DATA_W-1:0] c_out;
  logic [DATA_W-1:0] d_out;
  logic [3:0]        valid_out;
  logic [3:0]        ready_in;

  // Upstream producer plus downstream consumers.
  modport master (
    output sel_in, data_in, valid_in, ready_in,
    input  ready_out, a_out, b_out, c_out, d_out, valid_out
  );

  modport slave (
    input  sel_in, data_in, valid_in, ready_in,
    output ready_out, a_out, b_out, c_out, d_out, valid_out
  );

endinterface

// File: rtl/demux_1x4_stream_slot.sv
// One-entry registered output slot; optional drain counter under DEMUX_1X4_STATS_EN.
// Latency: 1 cycle load-to-valid. Backpressure: holds data/valid until rdy; reloads on same-cycle drain.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_dat,
  input  logic              rdy,
  output logic [DATA_W-1:0] dat,
  output logic              vld,
  output logic              drained
`ifdef DEMUX_1X4_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt
`endif
);

  slot_state_e       state_q;
  slot_state_e       state_d;
  logic [DATA_W-1:0] dat_q;

  assign vld     = (state_q == SLOT_FULL);
  assign drained = vld && rdy;
  assign dat     = dat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A load while FULL is only offered by the top when the slot drains that cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (load) state_d = SLOT_FULL;
      SLOT_FULL:  if (drained && !load) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // Data holds its last value once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_q <= '0;
    end else if (load) begin
      dat_q <= load_dat;
    end
  end

`ifdef DEMUX_1X4_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (drained) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/demux_1x4_stream.sv
// 1:4 stream demux routing each word by sel_in to a one-entry slot per channel; DEMUX_1X4_STATS_EN adds cnt_out.
// Latency: 1 cycle. Backpressure: ready_out drops only when the addressed slot is full and stalled.
module demux_1x4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  demux_1x4_stream_if.slave       bus
`ifdef DEMUX_1X4_STATS_EN
  ,
  output logic [CH_NUM*CNT_W-1:0] cnt_out
`endif
);

  logic [DATA_W-1:0] slot_dat [CH_NUM];
  logic [CH_NUM-1:0] slot_vld;
  logic [CH_NUM-1:0] slot_drained;
  logic [CH_NUM-1:0] load;
  logic              ready;
  logic              accept;
`ifdef DEMUX_1X4_STATS_EN
  logic [CNT_W-1:0]  slot_cnt [CH_NUM];
`endif

  // A full slot can take a new word only in the cycle it drains; never depends on valid_in.
  assign ready  = !rst_in && (!slot_vld[bus.sel_in] || slot_drained[bus.sel_in]);
  assign accept = bus.valid_in && ready;
  assign load   = accept ? sel_onehot(bus.sel_in) : '0;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk      (clk_in),
      .rst      (rst_in),
      .load     (load[i]),
      .load_dat (bus.data_in),
      .rdy      (bus.ready_in[i]),
      .dat      (slot_dat[i]),
      .vld      (slot_vld[i]),
      .drained  (slot_drained[i])
`ifdef DEMUX_1X4_STATS_EN
      ,
      .cnt      (slot_cnt[i])
`endif
    );
`ifdef DEMUX_1X4_STATS_EN
    assign cnt_out[i*CNT_W +: CNT_W] = slot_cnt[i];
`endif
  end

  assign bus.ready_out = ready;
  assign bus.valid_out = slot_vld;
  assign bus.a_out     = slot_dat[CH_A];
  assign bus.b_out     = slot_dat[CH_B];
  assign bus.c_out     = slot_dat[CH_C];
  assign bus.d_out     = slot_dat[CH_D];

  // Upstream must hold a stalled word until it is taken.
  a_stall_stable: assert property (
    @(posedge clk_in) disable iff (rst_in)
    (bus.valid_in && !ready) |=> (bus.valid_in && $stable(bus.sel_in) && $stable(bus.data_in))
  );

  a_one_load: assert property (
    @(posedge clk_in) disable iff (rst_in) $onehot0(load)
  );

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Scoreboard bench for demux_1x4_stream: per-channel expected queues, random plus directed traffic.
module tb_demux_1x4_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_1x4_stream_if #(.DATA_W(8)) bus ();

`ifdef DEMUX_1X4_STATS_EN
  logic [63:0] cnt_out;
`endif

  demux_1x4_stream #(.DATA_W(8)) dut (
    .clk_in  (clk),
    .rst_in  (rst),
    .bus     (bus)
`ifdef DEMUX_1X4_STATS_EN
    ,
    .cnt_out (cnt_out)
`endif
  );

  int total = 0;
  int bad   = 0;
  int stalls = 0;

  logic [7:0] q [4][$];
  logic [7:0] hold [4] = '{default: 8'h00};
  int         drains [4] = '{default: 0};

  logic       pend = 1'b0;
  logic [1:0] pend_sel = 2'd0;
  logic [7:0] pend_dat = 8'd0;

  task automatic check(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s ch=%0d actual=%0h required=%0h", name, ch, act, exp);
    end
  endtask

  function automatic logic [7:0] chan_dat(input int ch);
    case (ch)
      0:       return bus.a_out;
      1:       return bus.b_out;
      2:       return bus.c_out;
      default: return bus.d_out;
    endcase
  endfunction

  // Record handshakes away from the edge; the word enters the model at the edge it is accepted.
  initial forever begin
    @(negedge clk);
    pend     = bus.valid_in && bus.ready_out;
    pend_sel = bus.sel_in;
    pend_dat = bus.data_in;
  end

  initial forever begin
    @(posedge clk);
    if (pend) q[pend_sel].push_back(pend_dat);
  end

  // Monitor: a channel is valid exactly when its model queue holds a word.
  initial forever begin
    @(negedge clk);
    check("ready_out", bus.sel_in, bus.ready_out,
          !rst && (q[bus.sel_in].size() == 0 || bus.ready_in[bus.sel_in]));
    for (int ch = 0; ch < 4; ch++) begin
      check("valid_out", ch, bus.valid_out[ch], q[ch].size() > 0);
      check("data_out", ch, chan_dat(ch), (q[ch].size() > 0) ? q[ch][0] : hold[ch]);
`ifdef DEMUX_1X4_STATS_EN
      check("cnt_out", ch, cnt_out[ch*16 +: 16], drains[ch] & 32'hFFFF);
`endif
    end
    if (rst) begin
      for (int ch = 0; ch < 4; ch++) begin
        q[ch].delete();
        hold[ch]   = 8'h00;
        drains[ch] = 0;
      end
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        if (q[ch].size() > 0 && bus.ready_in[ch]) begin
          hold[ch] = q[ch].pop_front();
          drains[ch]++;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] s, input logic [7:0] d);
    int n = 0;
    bus.sel_in   = s;
    bus.data_in  = d;
    bus.valid_in = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.ready_out) break;
      stalls++;
      n++;
      if (n > 300) begin
        total++;
        bad++;
        $display("FAIL send_timeout sel=%0d data=%0h", s, d);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    cycles(n);
    rst = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.sel_in   = 2'd0;
    bus.data_in  = 8'd0;
    bus.ready_in = 4'b0000;
    cycles(3);
    rst = 1'b0;

    // Idle after reset.
    @(negedge clk);
    check("rst_valid", 0, {28'd0, bus.valid_out}, 32'h0);
    check("rst_data", 0, {bus.a_out, bus.b_out, bus.c_out, bus.d_out}, 32'h0);
    check("rst_ready", 0, {31'd0, bus.ready_out}, 32'h1);
    @(posedge clk);
    #1;

    // Routing.
    bus.ready_in = 4'b1111;
    send(2'd0, 8'h11);
    send(2'd1, 8'h22);
    send(2'd2, 8'h33);
    send(2'd3, 8'h44);
    cycles(3);
    check("route_a", 0, drains[0], 1);
    check("route_d", 3, drains[3], 1);

    // Isolation: channel a stalled, b waits behind the stalled word.
    bus.ready_in = 4'b1110;
    stalls       = 0;
    fork
      begin
        send(2'd0, 8'hA0);
        send(2'd0, 8'hA1);
        send(2'd1, 8'hB0);
      end
      begin
        cycles(6);
        bus.ready_in = 4'b1111;
      end
    join
    cycles(3);
    check("iso_stalled", 0, {31'd0, stalls > 0}, 32'h1);
    check("iso_b_hold", 1, {24'd0, bus.b_out}, 32'hB0);
    check("iso_a_hold", 0, {24'd0, bus.a_out}, 32'hA1);

    // Full throughput on c.
    bus.ready_in = 4'b0100;
    stalls       = 0;
    d0           = drains[2];
    for (int i = 1; i <= 16; i++) send(2'd2, 8'(i));
    cycles(3);
    check("thru_stalls", 2, stalls, 0);
    check("thru_beats", 2, drains[2] - d0, 16);

    // Reset with words buffered in a and d.
    bus.ready_in = 4'b0000;
    send(2'd0, 8'h5A);
    send(2'd3, 8'hD3);
    @(negedge clk);
    check("mid_fill", 0, {28'd0, bus.valid_out}, 32'h9);
    @(posedge clk);
    #1;
    do_reset(1);
    bus.ready_in = 4'b1111;
    cycles(5);
    @(negedge clk);
    check("mid_rst_valid", 0, {28'd0, bus.valid_out}, 32'h0);
    @(posedge clk);
    #1;

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (!bus.valid_in || pend) begin
        bus.valid_in = ($urandom_range(0, 3) != 0);
        bus.sel_in   = 2'($urandom_range(0, 3));
        bus.data_in  = 8'($urandom_range(0, 255));
      end
      bus.ready_in = 4'($urandom_range(0, 15));
      rst          = ($urandom_range(0, 199) == 0);
      cycles(1);
    end
    rst          = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 4'b1111;
    cycles(5);
    for (int ch = 0; ch < 4; ch++) check("drained_all", ch, q[ch].size(), 0);

`ifdef DEMUX_1X4_STATS_EN
    do_reset(2);
    bus.ready_in = 4'b1111;
    for (int i = 0; i < 3; i++) send(2'd1, 8'(i));
    for (int i = 0; i < 65537; i++) send(2'd2, 8'(i));
    cycles(3);
    check("cnt_b", 1, {16'd0, cnt_out[31:16]}, 32'd3);
    check("cnt_c", 2, {16'd0, cnt_out[47:32]}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_1x4_stream.md
Name: demux_1x4_stream

Overview:
- 1-to-4 stream demultiplexer with valid/ready handshake on every port.
- One input stream is routed to one of four output channels (a..d) chosen per word by sel_in.
- Each output channel has a one-entry registered slot, so outputs are registered and one busy channel does not block the others.
- Sits on the write side of the 4:1 channel mux path: it splits one stream into four, and the mux recombines them.

Parameters:
- DATA_W, 8, width of each data word.

Ports:
- clk_in  input  1  clock; all logic updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- sel_in  input  2  destination channel for the current word (00=a, 01=b, 10=c, 11=d).
- data_in  input  DATA_W  input word.
- valid_in  input  1  input word valid.
- ready_out  output  1  input may be accepted this cycle.
- a_out, b_out, c_out, d_out  output  DATA_W each  channel data.
- valid_out  output  4  per-channel valid; bit0=a .. bit3=d.
- ready_in  input  4  per-channel downstream ready; bit0=a .. bit3=d.

Behaviour:
- Reset: on a clock edge with rst_in=1:
  - valid_out=4'b0000.
  - a_out..d_out=0.
  - All slots EMPTY.
  - Any buffered words are discarded, including when reset is asserted mid-transfer.
  - ready_out is 0 while rst_in=1.
- Per-slot state machine (slot i):
  - EMPTY -> FULL on accept with sel_in=i.
  - FULL -> EMPTY on drain (valid_out[i] && ready_in[i]) with no accept to i in the same cycle.
  - FULL stays FULL on simultaneous drain and accept to i; the slot loads the new word.
- ready_out = !rst_in && (slot[sel_in] EMPTY || ready_in[sel_in]). This is combinational from sel_in and ready_in; there is no combinational path from valid_in.
- accept = valid_in && ready_out. On accept, slot[sel_in] data <= data_in at the same edge.
- Latency: a word accepted at edge N appears on its channel with valid_out set after edge N (one cycle).
- Upstream rule: while valid_in=1 and ready_out=0, sel_in and data_in must stay stable until accepted. The bench checks this; RTL behaviour is undefined if it is violated.
- Drain: a channel output holds its data and valid until ready_in is high. When not valid, the data output holds its last value.
- Ordering: words within one channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Back-pressure isolation: a full, stalled channel blocks only words addressed to it. The slot's one-entry capacity gives full throughput (1 word/cycle) per channel when ready_in is held high.
- All four channels can drain in the same cycle. At most one slot loads per cycle.

Optional Feature:
- Macro: DEMUX_1X4_STATS_EN.
- Defined:
  - Adds output port cnt_out (4x16 bits, packed, channel a in bits [15:0]).
  - Each 16-bit counter increments on a drain of its channel.
  - Counters wrap from 16'hFFFF to 0 and clear on reset.
- Undefined: no port, no counters; the rest of the behaviour is identical.

Decomposition:
- Package demux_pkg:
  - CH_NUM=4 and SEL_W=2.
  - Channel index enum CH_A=0, CH_B=1, CH_C=2, CH_D=3.
  - CNT_W=16 for the stats feature.
- Sub-module demux_slot, instantiated 4x: one-entry register slice with load, data, valid, ready and a drained flag, plus the optional counter.

Test Plan:
- Reset then idle -> valid_out=0000, all data outputs 0, ready_out=1 one cycle after rst_in falls.
- Routing: send 8'h11 sel=00, 8'h22 sel=01, 8'h33 sel=10, 8'h44 sel=11 with ready_in=1111 -> each value appears on a/b/c/d respectively, one cycle after its accept, and valid_out is one-hot per cycle.
- Isolation: ready_in=1110; send 8'hA0 sel=00, then 8'hA1 sel=00, then 8'hB0 sel=01 -> ready_out=0 on A1; B0 is still not accepted while A1 waits because the stable-input rule holds. Raise ready_in[0] -> a_out shows A0 then A1, then b_out shows B0.
- Full throughput: ready_in=0100; stream 8'h01..8'h10 to sel=10 on consecutive cycles -> no ready_out drop, c_out shows the sequence in order, 16 beats.
- Reset mid-operation: fill slots a and d, assert rst_in for one cycle -> valid_out=0000 and no stale word appears afterwards.
- With DEMUX_1X4_STATS_EN: drain 3 words on b and 65537 words on c -> cnt b=3, cnt c=1 (wrapped).
